// File: rtl/riscv_pkg.sv
// riscv_pkg: opcodes, control encodings and the immediate extender shared by the ID stage.
// Latency: n/a (types, constants and one combinational helper function).
// Backpressure: n/a.
package riscv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_J = 3'd3,
    IMM_U = 3'd4
  } imm_src_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctrl_t;

  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_LOAD = 2'b01,
    RES_PC4  = 2'b10
  } result_src_t;

  // use_rs1/use_rs2 tell the hazard logic which source fields are real
  // register reads for this format (I/U/J fields overlap immediate bits).
  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    logic        jump;
    logic        branch;
    logic        alu_src;
    result_src_t result_src;
    alu_ctrl_t   alu_ctrl;
    imm_src_t    imm_src;
    logic        use_rs1;
    logic        use_rs2;
  } ctrl_t;

  // Only instr[31:7] carries immediate bits; result is sign-extended to 32.
  function automatic logic [31:0] imm_extend(input logic [31:7] ib, input imm_src_t src);
    logic [31:0] imm;
    case (src)
      IMM_S:   imm = {{20{ib[31]}}, ib[31:25], ib[11:7]};
      IMM_B:   imm = {{20{ib[31]}}, ib[7], ib[30:25], ib[11:8], 1'b0};
      IMM_J:   imm = {{12{ib[31]}}, ib[19:12], ib[20], ib[30:21], 1'b0};
      IMM_U:   imm = {ib[31:12], 12'b0};
      default: imm = {{20{ib[31]}}, ib[31:20]};
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// decode_stage_if: IF/ID inputs, reg_file/WB ports and ID/EX outputs of the ID stage.
// Latency: n/a (wiring only); slave = decode stage, master = surrounding pipeline.
// Backpressure: stall_d flows back to IF; no other flow control.
interface decode_stage_if #(
  parameter int Width = 32
);
  logic [31:0]      instr_d;
  logic [Width-1:0] pc_d;
  logic [Width-1:0] pc_plus4_d;
  logic             valid_d;
  logic             flush_d;
  logic             flush_e;
  logic [4:0]       rs1_d;
  logic [4:0]       rs2_d;
  logic [Width-1:0] rd1_d;
  logic [Width-1:0] rd2_d;
  logic [4:0]       rd_w;
  logic             reg_write_w;
  logic [Width-1:0] result_w;
  logic             stall_d;
  logic             valid_e;
  logic [Width-1:0] rd1_e;
  logic [Width-1:0] rd2_e;
  logic [Width-1:0] imm_ext_e;
  logic [Width-1:0] pc_e;
  logic [Width-1:0] pc_plus4_e;
  logic [4:0]       rs1_e;
  logic [4:0]       rs2_e;
  logic [4:0]       rd_e;
  logic             reg_write_e;
  logic             mem_write_e;
  logic             jump_e;
  logic             branch_e;
  logic             alu_src_e;
  logic [1:0]       result_src_e;
  logic [2:0]       alu_ctrl_e;

  modport slave (
    input  instr_d, pc_d, pc_plus4_d, valid_d, flush_d, flush_e,
    input  rd1_d, rd2_d, rd_w, reg_write_w, result_w,
    output rs1_d, rs2_d, stall_d,
    output valid_e, rd1_e, rd2_e, imm_ext_e, pc_e, pc_plus4_e, rs1_e, rs2_e, rd_e,
    output reg_write_e, mem_write_e, jump_e, branch_e, alu_src_e, result_src_e, alu_ctrl_e
  );

  modport master (
    output instr_d, pc_d, pc_plus4_d, valid_d, flush_d, flush_e,
    output rd1_d, rd2_d, rd_w, reg_write_w, result_w,
    input  rs1_d, rs2_d, stall_d,
    input  valid_e, rd1_e, rd2_e, imm_ext_e, pc_e, pc_plus4_e, rs1_e, rs2_e, rd_e,
    input  reg_write_e, mem_write_e, jump_e, branch_e, alu_src_e, result_src_e, alu_ctrl_e
  );
endinterface

// File: rtl/decode_stage_ctrl_dec.sv
// ctrl_dec: RV32I main decoder + ALU decoder (opcode/funct3/funct7[5] -> controls, imm_src).
// Latency: purely combinational.
// Backpressure: none; unsupported opcodes decode to all-zero controls (NOP).
// Ports: opcode, funct3, funct7b5 in; ctrl (riscv_pkg::ctrl_t) out.
module ctrl_dec
  import riscv_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output ctrl_t      ctrl
);

  logic [1:0] alu_op;  // 00 add, 01 sub, 10 from funct3

  always_comb begin
    ctrl   = '0;
    alu_op = 2'b00;
    case (opcode)
      OP_LOAD: begin
        ctrl.reg_write  = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.result_src = RES_LOAD;
        ctrl.use_rs1    = 1'b1;
      end
      OP_STORE: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.imm_src   = IMM_S;
        ctrl.use_rs1   = 1'b1;
        ctrl.use_rs2   = 1'b1;
      end
      OP_RTYPE: begin
        ctrl.reg_write = 1'b1;
        ctrl.use_rs1   = 1'b1;
        ctrl.use_rs2   = 1'b1;
        alu_op         = 2'b10;
      end
      OP_IALU: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.use_rs1   = 1'b1;
        alu_op         = 2'b10;
      end
      OP_BRANCH: begin
        ctrl.branch  = 1'b1;
        ctrl.imm_src = IMM_B;
        ctrl.use_rs1 = 1'b1;
        ctrl.use_rs2 = 1'b1;
        alu_op       = 2'b01;
      end
      OP_JAL: begin
        ctrl.reg_write  = 1'b1;
        ctrl.jump       = 1'b1;
        ctrl.imm_src    = IMM_J;
        ctrl.result_src = RES_PC4;
      end
      OP_LUI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.imm_src   = IMM_U;
      end
      default: ;
    endcase

    case (alu_op)
      2'b00: ctrl.alu_ctrl = ALU_ADD;
      2'b01: ctrl.alu_ctrl = ALU_SUB;
      default: begin
        case (funct3)
          // funct7[5] selects sub only for R-type; for addi it is an immediate bit.
          3'b000:  ctrl.alu_ctrl = (opcode == OP_RTYPE && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  ctrl.alu_ctrl = ALU_SLT;
          3'b110:  ctrl.alu_ctrl = ALU_OR;
          3'b111:  ctrl.alu_ctrl = ALU_AND;
          default: ctrl.alu_ctrl = ALU_ADD;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: RV32I ID stage -- decode, imm extend, x0/WB operand select, hazards, ID/EX register.
// Latency: one cycle instr_d -> *_e; stall_d is combinational in the decode cycle.
// Backpressure: load-use (and WB read hazard without `DECODE_WB_BYPASS_EN) raises stall_d and loads a bubble.
// Ports: clk, rst_n (async active-low), bus (decode_stage_if.slave: IF/ID, reg_file a1/a2/rd1/rd2, WB, ID/EX).
// Option: `DECODE_WB_BYPASS_EN forwards result_w into a same-cycle matching operand instead of stalling.
module decode_stage
  import riscv_pkg::*;
#(
  parameter int Width = 32
) (
  input logic           clk,
  input logic           rst_n,
  decode_stage_if.slave bus
);

  typedef struct packed {
    logic        valid;
    logic [Width-1:0] rd1;
    logic [Width-1:0] rd2;
    logic [Width-1:0] imm;
    logic [Width-1:0] pc;
    logic [Width-1:0] pc4;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_write;
    logic        jump;
    logic        branch;
    logic        alu_src;
    result_src_t result_src;
    alu_ctrl_t   alu_ctrl;
  } idex_t;

  ctrl_t              ctrl;
  logic [4:0]         rs1, rs2, rd;
  logic signed [31:0] imm32;
  logic [Width-1:0]   op1, op2;
  logic               wb_hit1, wb_hit2;
  logic               live, lu, stall, bubble;
  idex_t              ex_d, ex_q;

  ctrl_dec u_ctrl_dec (
    .opcode   (bus.instr_d[6:0]),
    .funct3   (bus.instr_d[14:12]),
    .funct7b5 (bus.instr_d[30]),
    .ctrl     (ctrl)
  );

  assign rs1       = bus.instr_d[19:15];
  assign rs2       = bus.instr_d[24:20];
  assign rd        = bus.instr_d[11:7];
  assign bus.rs1_d = rs1;
  assign bus.rs2_d = rs2;
  assign imm32     = imm_extend(bus.instr_d[31:7], ctrl.imm_src);

  // reg_file is written at the edge ending this cycle, so its read port still shows the old value.
  assign wb_hit1 = bus.reg_write_w && (bus.rd_w != 5'd0) && (bus.rd_w == rs1);
  assign wb_hit2 = bus.reg_write_w && (bus.rd_w != 5'd0) && (bus.rd_w == rs2);

  always_comb begin
    op1 = bus.rd1_d;
    op2 = bus.rd2_d;
`ifdef DECODE_WB_BYPASS_EN
    if (wb_hit1) op1 = bus.result_w;
    if (wb_hit2) op2 = bus.result_w;
`endif
    // x0 wins over everything, including a (malformed) bypass.
    if (rs1 == 5'd0) op1 = '0;
    if (rs2 == 5'd0) op2 = '0;
  end

  assign live = bus.valid_d && !bus.flush_d;
  assign lu   = ex_q.valid && (ex_q.result_src == RES_LOAD) && (ex_q.rd != 5'd0) &&
                ((ctrl.use_rs1 && ex_q.rd == rs1) || (ctrl.use_rs2 && ex_q.rd == rs2)) && live;

`ifdef DECODE_WB_BYPASS_EN
  assign stall = lu;
`else
  // Without the bypass the matching operand is re-read next cycle, after the write lands.
  assign stall = lu || (((ctrl.use_rs1 && wb_hit1) || (ctrl.use_rs2 && wb_hit2)) && live);
`endif

  assign bus.stall_d = stall;
  assign bubble      = bus.flush_e || stall || bus.flush_d || !bus.valid_d;

  always_comb begin
    ex_d            = '0;
    ex_d.valid      = 1'b1;
    ex_d.rd1        = op1;
    ex_d.rd2        = op2;
    ex_d.imm        = Width'(imm32);
    ex_d.pc         = bus.pc_d;
    ex_d.pc4        = bus.pc_plus4_d;
    ex_d.rs1        = rs1;
    ex_d.rs2        = rs2;
    ex_d.rd         = rd;
    ex_d.reg_write  = ctrl.reg_write;
    ex_d.mem_write  = ctrl.mem_write;
    ex_d.jump       = ctrl.jump;
    ex_d.branch     = ctrl.branch;
    ex_d.alu_src    = ctrl.alu_src;
    ex_d.result_src = ctrl.result_src;
    ex_d.alu_ctrl   = ctrl.alu_ctrl;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q <= '0;
    end else if (bubble) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  assign bus.valid_e      = ex_q.valid;
  assign bus.rd1_e        = ex_q.rd1;
  assign bus.rd2_e        = ex_q.rd2;
  assign bus.imm_ext_e    = ex_q.imm;
  assign bus.pc_e         = ex_q.pc;
  assign bus.pc_plus4_e   = ex_q.pc4;
  assign bus.rs1_e        = ex_q.rs1;
  assign bus.rs2_e        = ex_q.rs2;
  assign bus.rd_e         = ex_q.rd;
  assign bus.reg_write_e  = ex_q.reg_write;
  assign bus.mem_write_e  = ex_q.mem_write;
  assign bus.jump_e       = ex_q.jump;
  assign bus.branch_e     = ex_q.branch;
  assign bus.alu_src_e    = ex_q.alu_src;
  assign bus.result_src_e = ex_q.result_src;
  assign bus.alu_ctrl_e   = ex_q.alu_ctrl;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: scoreboard bench for decode_stage with a mnemonic-level reference model.
// Latency: expects ID/EX content one edge after issue; stall_d within the issue cycle.
// Backpressure: the bench re-presents an instruction while its model predicts a stall.
module tb_decode_stage;

  localparam int W = 32;
`ifdef DECODE_WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  decode_stage_if #(.Width(W)) bus ();
  decode_stage #(.Width(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // Behavioural register file: combinational read, write applied after each edge.
  logic [31:0] regs [0:31];
  assign bus.rd1_d = regs[bus.rs1_d];
  assign bus.rd2_d = regs[bus.rs2_d];

  typedef struct packed {
    logic        valid;
    logic [31:0] rd1, rd2, imm, pc, pc4;
    logic [4:0]  rs1, rs2, rd;
    logic        reg_write, mem_write, jump, branch, alu_src;
    logic [1:0]  result_src;
    logic [2:0]  alu_ctrl;
  } ex_t;

  ex_t  exe_q[$];
  logic stall_q[$];
  ex_t  m_ex, m_next;
  logic [31:0] pc = 32'h0000_1000;
  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [2:0] alu_of(input logic [2:0] f3, input logic sub);
    case (f3)
      3'b000:  return sub ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  // {reads rs1, reads rs2} by instruction class.
  function automatic logic [1:0] uses(input logic [31:0] ins);
    case (ins[6:0])
      7'h03, 7'h13:        return 2'b10;
      7'h23, 7'h33, 7'h63: return 2'b11;
      default:             return 2'b00;
    endcase
  endfunction

  function automatic ex_t predict(input logic [31:0] ins, input logic [31:0] p,
                                  input logic [31:0] a, input logic [31:0] b);
    ex_t e;
    logic [31:0] sgn, imm_i, imm_s, imm_b, imm_j, imm_u;
    sgn   = 32'($signed(ins) >>> 31);
    imm_i = 32'($signed(ins) >>> 20);
    imm_s = (32'($signed(ins) >>> 25) << 5) | 32'(ins[11:7]);
    imm_b = (sgn << 12) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
    imm_j = (sgn << 20) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
    imm_u = ins & 32'hFFFF_F000;
    e = '0;
    e.valid = 1'b1; e.rd1 = a; e.rd2 = b; e.pc = p; e.pc4 = p + 32'd4;
    e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7]; e.imm = imm_i;
    case (ins[6:0])
      7'h03: begin e.reg_write = 1; e.alu_src = 1; e.result_src = 2'b01; end                // lw
      7'h23: begin e.mem_write = 1; e.alu_src = 1; e.imm = imm_s; end                       // sw
      7'h33: begin e.reg_write = 1; e.alu_ctrl = alu_of(ins[14:12], ins[30]); end           // R
      7'h13: begin e.reg_write = 1; e.alu_src = 1; e.alu_ctrl = alu_of(ins[14:12], 1'b0); end // I
      7'h63: begin e.branch = 1; e.alu_ctrl = 3'b001; e.imm = imm_b; end                    // beq
      7'h6F: begin e.jump = 1; e.reg_write = 1; e.result_src = 2'b10; e.imm = imm_j; end    // jal
      7'h37: begin e.reg_write = 1; e.alu_src = 1; e.imm = imm_u; end                       // lui
      default: ;
    endcase
    return e;
  endfunction

  function automatic logic [31:0] operand(input logic [4:0] rs, input logic rw,
                                          input logic [4:0] rdw, input logic [31:0] res);
    if (rs == 5'd0) return 32'd0;
    if (BYPASS && rw && rdw == rs) return res;
    return regs[rs];
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    logic [2:0]  f3s [4];
    f3s[0] = 3'b000; f3s[1] = 3'b010; f3s[2] = 3'b110; f3s[3] = 3'b111;
    ins = $urandom;
    ins[19:15] = 5'($urandom_range(0, 7));
    ins[24:20] = 5'($urandom_range(0, 7));
    ins[11:7]  = 5'($urandom_range(0, 7));
    case ($urandom_range(0, 7))
      0: begin ins[6:0] = 7'h03; ins[14:12] = 3'b010; end
      1: begin ins[6:0] = 7'h23; ins[14:12] = 3'b010; end
      2: begin ins[6:0] = 7'h33; ins[14:12] = f3s[$urandom_range(0, 3)];
               ins[31:25] = {1'b0, 1'($urandom_range(0, 1)), 5'b0}; end
      3: begin ins[6:0] = 7'h13; ins[14:12] = f3s[$urandom_range(0, 3)]; end
      4: begin ins[6:0] = 7'h63; ins[14:12] = 3'b000; end
      5: ins[6:0] = 7'h6F;
      6: ins[6:0] = 7'h37;
      default: ins[6:0] = 7'h73;
    endcase
    return ins;
  endfunction

  // One clock cycle: apply last cycle's WB write, drive new inputs, queue expectations.
  task automatic step(input logic [31:0] ins, input logic v, input logic fd, input logic fe,
                      input logic rw, input logic [4:0] rdw, input logic [31:0] res,
                      input logic rst, output logic st);
    logic [1:0] u;
    logic lu, wbm;
    @(posedge clk);
    #1;
    if (bus.reg_write_w && bus.rd_w != 5'd0) regs[bus.rd_w] = bus.result_w;
    rst_n = ~rst;
    m_ex  = rst ? ex_t'(0) : m_next;
    bus.instr_d = ins; bus.pc_d = pc; bus.pc_plus4_d = pc + 32'd4;
    bus.valid_d = v; bus.flush_d = fd; bus.flush_e = fe;
    bus.reg_write_w = rw; bus.rd_w = rdw; bus.result_w = res;
    u   = uses(ins);
    lu  = m_ex.valid && m_ex.result_src == 2'b01 && m_ex.rd != 0 &&
          ((u[1] && m_ex.rd == ins[19:15]) || (u[0] && m_ex.rd == ins[24:20])) && v && !fd;
    wbm = rw && rdw != 0 && ((u[1] && rdw == ins[19:15]) || (u[0] && rdw == ins[24:20])) && v && !fd;
    st  = lu || (!BYPASS && wbm);
    if (rst || fe || st || fd || !v) m_next = '0;
    else m_next = predict(ins, pc, operand(ins[19:15], rw, rdw, res), operand(ins[24:20], rw, rdw, res));
    stall_q.push_back(st);
    exe_q.push_back(m_ex);
  endtask

  task automatic idle();
    logic st;
    step(32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, st);
  endtask

  // Issue one instruction, re-presenting it while the model predicts a stall.
  task automatic issue(input logic [31:0] ins, input logic rw, input logic [4:0] rdw,
                       input logic [31:0] res, output int nst);
    logic st;
    nst = 0;
    step(ins, 1'b1, 1'b0, 1'b0, rw, rdw, res, 1'b0, st);
    while (st && nst < 8) begin
      nst++;
      step(ins, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, st);
    end
    pc = pc + 32'd4;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  // Monitor: every cycle the ID/EX register and stall_d are presented; compare against the queue heads.
  always @(negedge clk) begin
    if (stall_q.size() != 0) begin
      ex_t act, exp;
      logic exp_st;
      exp_st = stall_q.pop_front();
      exp    = exe_q.pop_front();
      act.valid = bus.valid_e; act.rd1 = bus.rd1_e; act.rd2 = bus.rd2_e; act.imm = bus.imm_ext_e;
      act.pc = bus.pc_e; act.pc4 = bus.pc_plus4_e; act.rs1 = bus.rs1_e; act.rs2 = bus.rs2_e;
      act.rd = bus.rd_e; act.reg_write = bus.reg_write_e; act.mem_write = bus.mem_write_e;
      act.jump = bus.jump_e; act.branch = bus.branch_e; act.alu_src = bus.alu_src_e;
      act.result_src = bus.result_src_e; act.alu_ctrl = bus.alu_ctrl_e;
      n_cmp++;
      if (act !== exp) begin
        n_bad++;
        $display("FAIL idex_reg @%0t: got %h want %h", $time, act, exp);
      end
      n_cmp++;
      if (bus.stall_d !== exp_st) begin
        n_bad++;
        $display("FAIL stall_d @%0t: got %b want %b", $time, bus.stall_d, exp_st);
      end
    end
  end

  initial begin
    logic st, hold, v, fl, rw, rs;
    logic [31:0] ins, res;
    logic [4:0]  rdw;
    int nst;
    rst_n = 1'b0;
    bus.instr_d = '0; bus.pc_d = '0; bus.pc_plus4_d = '0; bus.valid_d = 1'b0;
    bus.flush_d = 1'b0; bus.flush_e = 1'b0; bus.rd_w = '0; bus.reg_write_w = 1'b0; bus.result_w = '0;
    for (int i = 0; i < 32; i++) regs[i] = (i == 0) ? 32'd0 : $urandom;
    m_next = '0;

    repeat (2) step(32'hFFD00293, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, st);

    // addi x5,x0,-3
    issue(32'hFFD00293, 1'b0, 5'd0, 32'd0, nst);
    idle();
    chk("addi_imm", bus.imm_ext_e, 32'hFFFF_FFFD);
    chk("addi_rd", 32'(bus.rd_e), 32'd5);
    chk("addi_ctl", {30'd0, bus.alu_src_e, bus.reg_write_e}, 32'd3);

    // lw x6,0(x1); add x7,x6,x2 -> one load-use stall
    issue(32'h0000A303, 1'b0, 5'd0, 32'd0, nst);
    issue(32'h002303B3, 1'b0, 5'd0, 32'd0, nst);
    chk("lu_stall_cycles", nst, 32'd1);
    idle();

    // WB x3 <= DEADBEEF while decoding add x4,x3,x3
    issue(32'h00318233, 1'b1, 5'd3, 32'hDEAD_BEEF, nst);
    chk("wb_stall_cycles", nst, BYPASS ? 32'd0 : 32'd1);
    idle();
    chk("wb_rd1", bus.rd1_e, 32'hDEAD_BEEF);
    chk("wb_rd2", bus.rd2_e, 32'hDEAD_BEEF);

    // flush_e together with load-use; then x0 operand with an x0 WB write
    issue(32'h0000A303, 1'b0, 5'd0, 32'd0, nst);
    step(32'h002303B3, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, st);
    idle();
    step(32'h00000433, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 32'h1234_5678, 1'b0, st);
    idle();
    chk("x0_rd1", bus.rd1_e, 32'd0);

    // reset asserted between edges while a real instruction sits in ID/EX
    issue(32'hFFD00293, 1'b0, 5'd0, 32'd0, nst);
    step(32'h00318233, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, st);

    // beq x1,x2,-8 and jal x1,+2048, first after reset release
    issue(32'hFE208CE3, 1'b0, 5'd0, 32'd0, nst);
    idle();
    chk("beq_imm", bus.imm_ext_e, 32'hFFFF_FFF8);
    chk("beq_ctl", {28'd0, bus.branch_e, bus.alu_ctrl_e}, 32'h9);
    issue(32'h001000EF, 1'b0, 5'd0, 32'd0, nst);
    idle();
    chk("jal_imm", bus.imm_ext_e, 32'h0000_0800);
    chk("jal_ctl", {29'd0, bus.jump_e, bus.result_src_e}, 32'h6);

    // randomized stream
    hold = 1'b0; ins = '0; v = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (!hold) begin
        ins = rand_instr();
        v   = ($urandom_range(0, 7) != 0);
      end
      fl  = ($urandom_range(0, 11) == 0);
      rs  = ($urandom_range(0, 99) == 0);
      rw  = 1'($urandom_range(0, 1));
      rdw = 5'($urandom_range(0, 7));
      res = $urandom;
      step(ins, v, fl, fl, rw, rdw, res, rs, st);
      hold = st;
      if (!hold) pc = pc + 32'd4;
    end

    repeat (3) idle();
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
